// File: rtl/vx_tex_port_arb.sv
// Multi-port texture request front-end.
// Round-robin arbitrates NUM_INPUTS request channels into one texture pipeline,
// tags each request with its source port, routes responses back by that index,
// limits per-port outstanding requests and counts per-port stall cycles.
module vx_tex_port_arb #(
   parameter int unsigned NUM_INPUTS  = 4,
   parameter int unsigned NUM_LANES   = 4,
   parameter int unsigned TAG_WIDTH   = 8,
   parameter int unsigned LOD_BITS    = 4,
   parameter int unsigned STAGE_BITS  = 1,
   parameter int unsigned MAX_PENDING = 8,
   parameter int unsigned SEL_BITS    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
   parameter int unsigned PERF_BITS   = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_INPUTS-1:0]                 in_req_valid,
   input  logic [NUM_INPUTS*NUM_LANES-1:0]       in_req_mask,
   input  logic [NUM_INPUTS*2*NUM_LANES*32-1:0]  in_req_coords,
   input  logic [NUM_INPUTS*NUM_LANES*LOD_BITS-1:0] in_req_lod,
   input  logic [NUM_INPUTS*STAGE_BITS-1:0]      in_req_stage,
   input  logic [NUM_INPUTS*TAG_WIDTH-1:0]       in_req_tag,
   output logic [NUM_INPUTS-1:0]                 in_req_ready,
   output logic [NUM_INPUTS-1:0]                 in_rsp_valid,
   output logic [NUM_INPUTS*NUM_LANES*32-1:0]    in_rsp_texels,
   output logic [NUM_INPUTS*TAG_WIDTH-1:0]       in_rsp_tag,
   input  logic [NUM_INPUTS-1:0]                 in_rsp_ready,
   output logic                                  out_req_valid,
   output logic [NUM_LANES-1:0]                  out_req_mask,
   output logic [2*NUM_LANES*32-1:0]             out_req_coords,
   output logic [NUM_LANES*LOD_BITS-1:0]         out_req_lod,
   output logic [STAGE_BITS-1:0]                 out_req_stage,
   output logic [TAG_WIDTH+SEL_BITS-1:0]         out_req_tag,
   input  logic                                  out_req_ready,
   input  logic                                  out_rsp_valid,
   input  logic [NUM_LANES*32-1:0]               out_rsp_texels,
   input  logic [TAG_WIDTH+SEL_BITS-1:0]         out_rsp_tag,
   output logic                                  out_rsp_ready,
   output logic [NUM_INPUTS*PERF_BITS-1:0]       perf_stall_cycles
);

   localparam int unsigned PW = $clog2(MAX_PENDING + 1);
   localparam int unsigned CW = 2 * NUM_LANES * 32;
   localparam int unsigned LW = NUM_LANES * LOD_BITS;
   localparam int unsigned XW = TAG_WIDTH + SEL_BITS;
   localparam int unsigned DW = NUM_LANES * 32;
   localparam int unsigned PL = NUM_LANES + CW + LW + STAGE_BITS + XW;

   logic [PW-1:0]         pending [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] eligible;
   logic [NUM_INPUTS-1:0] rot;
   logic [SEL_BITS-1:0]   rr_ptr;
   logic [SEL_BITS-1:0]   grant;
   logic                  found;
   logic                  can_accept;
   logic                  req_fire;
   logic                  out_fire;
   logic [PL-1:0]         sel_payload;
   logic [PL-1:0]         ent0;
   logic [PL-1:0]         ent1;
   logic [1:0]            cnt;
   logic [NUM_INPUTS-1:0] rb_valid;
   logic [SEL_BITS-1:0]   rsp_sel;
   logic                  rsp_fire;
   logic [NUM_INPUTS-1:0] rsp_dec;

   // A port may compete only while it is below its outstanding-request limit.
   always_comb begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         eligible[i] = in_req_valid[i] && (pending[i] != PW'(MAX_PENDING));
      end
   end

   // Round-robin search: rotate so rr_ptr lands at bit 0, take the first set bit.
   always_comb begin
      rot   = NUM_INPUTS'({eligible, eligible} >> rr_ptr);
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            grant = SEL_BITS'((32'(rr_ptr) + k) % NUM_INPUTS);
         end
      end
   end

   assign can_accept = (cnt != 2'd2);
   assign req_fire   = found && can_accept;

   // One-hot accept and payload mux for the granted port; tag gets the port index appended.
   always_comb begin
      in_req_ready = '0;
      sel_payload  = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (grant == SEL_BITS'(i)) begin
            in_req_ready[i] = req_fire;
            sel_payload = {in_req_mask[i*NUM_LANES +: NUM_LANES],
                           in_req_coords[i*CW +: CW],
                           in_req_lod[i*LW +: LW],
                           in_req_stage[i*STAGE_BITS +: STAGE_BITS],
                           in_req_tag[i*TAG_WIDTH +: TAG_WIDTH],
                           SEL_BITS'(i)};
         end
      end
   end

   assign {out_req_mask, out_req_coords, out_req_lod, out_req_stage, out_req_tag} = ent0;
   assign out_req_valid = (cnt != 2'd0);
   assign out_fire      = out_req_valid && out_req_ready;

   // Two-entry skid buffer; ent0 is always the head presented downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= 2'd0;
         ent0   <= '0;
         ent1   <= '0;
         rr_ptr <= '0;
      end else begin
         if (req_fire) begin
            rr_ptr <= SEL_BITS'((32'(grant) + 1) % NUM_INPUTS);
         end
         case (cnt)
            2'd0: begin
               if (req_fire) begin
                  ent0 <= sel_payload;
                  cnt  <= 2'd1;
               end
            end
            2'd1: begin
               if (req_fire && out_fire) begin
                  ent0 <= sel_payload;
               end else if (req_fire) begin
                  ent1 <= sel_payload;
                  cnt  <= 2'd2;
               end else if (out_fire) begin
                  cnt  <= 2'd0;
               end
            end
            default: begin
               if (out_fire) begin
                  ent0 <= ent1;
                  cnt  <= 2'd1;
               end
            end
         endcase
      end
   end

   assign rsp_sel = out_rsp_tag[SEL_BITS-1:0];

   // Head response is accepted only if its target buffer is free or draining now.
   always_comb begin
      out_rsp_ready = 1'b1;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (rsp_sel == SEL_BITS'(i)) begin
            out_rsp_ready = !rb_valid[i] || in_rsp_ready[i];
         end
      end
   end

   assign rsp_fire     = out_rsp_valid && out_rsp_ready;
   assign in_rsp_valid = rb_valid;
   assign rsp_dec      = rb_valid & in_rsp_ready;

   // Per-port one-entry response buffers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rb_valid      <= '0;
         in_rsp_texels <= '0;
         in_rsp_tag    <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_fire && (rsp_sel == SEL_BITS'(i))) begin
               rb_valid[i]                       <= 1'b1;
               in_rsp_texels[i*DW +: DW]         <= out_rsp_texels;
               in_rsp_tag[i*TAG_WIDTH +: TAG_WIDTH] <= out_rsp_tag[XW-1:SEL_BITS];
            end else if (in_rsp_ready[i]) begin
               rb_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Outstanding-request counters and saturating stall counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            pending[i] <= '0;
         end
         perf_stall_cycles <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (in_req_ready[i] && !rsp_dec[i]) begin
               pending[i] <= pending[i] + 1'b1;
            end else if (rsp_dec[i] && !in_req_ready[i] && (pending[i] != '0)) begin
               pending[i] <= pending[i] - 1'b1;
            end
            if (in_req_valid[i] && !in_req_ready[i] &&
                (perf_stall_cycles[i*PERF_BITS +: PERF_BITS] != '1)) begin
               perf_stall_cycles[i*PERF_BITS +: PERF_BITS] <=
                  perf_stall_cycles[i*PERF_BITS +: PERF_BITS] + 1'b1;
            end
         end
      end
   end

   a_onehot_ready: assert property (@(posedge clk) disable iff (reset) $onehot0(in_req_ready));

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chk
      a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                                       rsp_dec[g] |-> (pending[g] != '0));
   end

endmodule
